// File: rtl/instr_fetch.sv
// instr_fetch -- single-outstanding-request instruction fetch unit.
//
// Issues one word-aligned read to instruction memory at a time, registers
// the returned word for the decode stage behind a valid/ready handshake,
// and follows branch/jump redirects. A redirect that arrives while a read
// is already committed marks that read's response for discard.
//
// Optional build macro: IFETCH_PERF_EN adds the fetch_count and
// redirect_count performance counter outputs.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_req/imem_addr    read request and word-aligned address
//   imem_gnt              memory accepts the request this cycle
//   imem_rvalid/rdata     read response
//   redirect/redirect_pc  taken branch/jump and its target
//   instr_valid/ready     handshake toward decode
//   instr/instr_pc        fetched word and its address
//   opcode                instr[31:26]
//   fetch_count           (IFETCH_PERF_EN) instructions delivered
//   redirect_count        (IFETCH_PERF_EN) cycles with an active redirect
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [5:0]  opcode
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] redirect_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        drop, drop_nxt;
    logic        valid_nxt;
    logic        load;
    logic        redir_act;

    assign redir_act = redirect && (state != S_IDLE);
    assign imem_addr = pc;
    assign opcode    = instr[31:26];

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        drop_nxt  = drop;
        load      = 1'b0;
        imem_req  = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                imem_req = !instr_valid || instr_ready;
                if (imem_req && imem_gnt) begin
                    state_nxt = S_WAIT;
                    // Request already committed to the old pc: discard its data.
                    if (redirect) drop_nxt = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = S_REQ;
                    drop_nxt  = 1'b0;
                    // A redirect coinciding with the response consumes it
                    // here, so no drop is left pending for a response that
                    // will never come.
                    if (!drop && !redirect) begin
                        load   = 1'b1;
                        pc_nxt = pc + 32'd4;
                    end
                end else if (redirect) begin
                    drop_nxt = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // Redirect target wins over sequential pc+4.
        if (redir_act) pc_nxt = redirect_pc & 32'hFFFF_FFFC;

        if (load)
            valid_nxt = 1'b1;
        else if (redir_act || instr_ready)
            valid_nxt = 1'b0;
        else
            valid_nxt = instr_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            drop        <= drop_nxt;
            instr_valid <= valid_nxt;
            if (load) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count    <= '0;
            redirect_count <= '0;
        end else begin
            if (load)      fetch_count    <= fetch_count + 32'd1;
            if (redir_act) redirect_count <= redirect_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, byte address of the first fetched instruction.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  32  word-aligned fetch address; valid while imem_req=1.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- redirect  in  1  taken branch or jump; overrides sequential PC.
- redirect_pc  in  32  redirect target address.
- instr_valid  out  1  instr/instr_pc hold a fetched instruction.
- instr_ready  in  1  decode stage consumes the instruction this cycle.
- instr  out  32  fetched instruction word.
- instr_pc  out  32  address of instr.
- opcode  out  6  instr[31:26], feeds the main decoder.

Function
REQ-003 SHALL implement FSM states S_IDLE, S_REQ and S_WAIT.
REQ-004 S_IDLE SHALL be the reset state and SHALL move to S_REQ on the first clock edge after rst_n deasserts.
REQ-005 In S_REQ, imem_req SHALL equal (!instr_valid | instr_ready), with imem_addr = pc.
REQ-006 When imem_req and imem_gnt are both 1, the FSM SHALL move to S_WAIT; otherwise it SHALL stay in S_REQ with imem_addr held.
REQ-007 Exactly one request SHALL be outstanding; imem_req SHALL be 0 in S_IDLE and S_WAIT.
REQ-008 In S_WAIT, on imem_rvalid=1 with drop=0, the block SHALL register instr=imem_rdata, instr_pc=pc, instr_valid=1 and pc=pc+4, then return to S_REQ.
REQ-009 Handshake: instr_valid SHALL clear on an edge with instr_ready=1 unless a new instruction loads that edge; instr, instr_pc and opcode SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-010 Minimum latency SHALL be: grant in cycle N, rvalid in N+1, instr_valid in N+2; peak throughput is one instruction per two cycles.
REQ-011 redirect=1 in any state except S_IDLE SHALL set pc={redirect_pc[31:2],2'b00} and clear instr_valid on the same edge.
REQ-012 A redirect while in S_WAIT, or in S_REQ on the same cycle as a grant, SHALL set drop=1; the next rvalid SHALL be discarded (no output, pc unchanged), drop SHALL clear, and the FSM SHALL go to S_REQ.
REQ-013 A redirect on the same cycle as a non-dropped rvalid SHALL discard that response; redirect has priority over pc+4.
REQ-014 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-015 imem_rvalid in S_IDLE or S_REQ SHALL be ignored.

Reset
REQ-016 While rst_n=0, the block SHALL hold: state=S_IDLE, pc=RESET_PC, drop=0, instr_valid=0, instr=0, instr_pc=0, opcode=0, imem_req=0, imem_addr=RESET_PC.
REQ-017 Reset asserted mid-transaction SHALL abandon the outstanding request; a stale rvalid after release SHALL be ignored per REQ-015.

Configuration
REQ-018 With IFETCH_PERF_EN defined, the block SHALL add outputs fetch_count (32, out) and redirect_count (32, out), both reset to 0 and wrapping modulo 2^32.
- fetch_count SHALL increment per instruction delivered (REQ-008).
- redirect_count SHALL increment per cycle with redirect=1 outside S_IDLE.
REQ-019 Without IFETCH_PERF_EN, those ports and counters SHALL be absent, with no other behavioural difference.

Verification
REQ-020 Bench SHALL cover:
- Reset release, RESET_PC=0, gnt always 1, rvalid one cycle after grant, instr_ready=1 -> imem_addr 0,4,8 on successive requests; instr_pc 0,4,8 with matching rdata.
- Data 32'h8C01_0004 returned -> opcode=6'b100011 while instr_valid=1.
- instr_ready=0 for 5 cycles -> instr held stable, no new imem_req, and exactly one request issued after ready rises.
- redirect=1, redirect_pc=32'h0000_0042 while in S_WAIT -> pending response dropped, next imem_addr=32'h0000_0040, instr_valid stays 0 until that fetch returns.
- pc=32'hFFFF_FFFC fetched -> next imem_addr=32'h0000_0000.
- rst_n pulsed low while in S_WAIT -> all outputs at reset values immediately; after release the first imem_addr is RESET_PC; with IFETCH_PERF_EN, both counters equal 0.
